// File: rtl/fetch_stage.sv
// Fetch stage: PC generation, credit-limited instruction memory requests, response buffer FIFO
// and registered {fetch_pc, fetch_inst} to decode. Optional FETCH_PERF_CTR_EN adds perf counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        decode_stall,
  input  logic        decode_flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst
`ifdef FETCH_PERF_CTR_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_t           state;
  state_t           state_next;
  logic [31:0]      pc;
  logic [31:0]      resp_pc;
  logic [31:0]      redirect_aligned;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] stale;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  entry_t           fifo_mem [FIFO_DEPTH];
  entry_t           fifo_head;
  logic             credit_ok;
  logic             req_fire;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign fifo_empty       = (fifo_count == '0);
  assign fifo_head        = fifo_mem[rd_ptr];

  // Every issued fetch owns a FIFO slot until it is popped, so the FIFO can never overflow.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);

  assign imem_req_valid = (state == S_RUN) && !decode_flush && credit_ok;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses for fetches issued before a flush are counted down and discarded.
  assign push  = imem_resp_valid && !decode_flush && (drop_cnt == '0);
  assign pop   = !decode_flush && !decode_stall && !fifo_empty;
  assign stale = outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_BOOT:  state_next = S_RUN;
      S_RUN:   state_next = S_RUN;
      S_DRAIN: begin
        if ((drop_cnt == '0) || (imem_resp_valid && (drop_cnt == CNT_W'(1)))) begin
          state_next = S_RUN;
        end
      end
      default: state_next = S_BOOT;
    endcase
    if (decode_flush) begin
      state_next = (stale != '0) ? S_DRAIN : S_RUN;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_next;
      outstanding <= stale;
      if (decode_flush) begin
        pc       <= redirect_aligned;
        resp_pc  <= redirect_aligned;
        drop_cnt <= stale;
      end else begin
        if (req_fire) begin
          pc <= pc + 32'd4;
        end
        if (imem_resp_valid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (decode_flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: buffer storage has no reset; fifo_count alone decides which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{pc: resp_pc, inst: imem_resp_data};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fetch_pc   <= '0;
      fetch_inst <= '0;
    end else if (decode_flush) begin
      fetch_pc   <= '0;
      fetch_inst <= '0;
    end else if (!decode_stall) begin
      if (!fifo_empty) begin
        fetch_pc   <= fifo_head.pc;
        fetch_inst <= fifo_head.inst;
      end else begin
        fetch_pc   <= '0;
        fetch_inst <= '0;
      end
    end
  end

`ifdef FETCH_PERF_CTR_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (push) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (!decode_flush && !decode_stall && fifo_empty) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (push && !pop) |-> (fifo_count < CNT_W'(FIFO_DEPTH)));
  a_no_orphan_resp: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    imem_resp_valid |-> (outstanding != '0));

endmodule
